// File: rtl/arbitro_memoria_dados.sv
// Purpose : shares the single MemoriaDados port between the nRisc load/store path (port 0) and a loader/debug master (port 1).
// Latency : write -> EscMem + Ack one cycle after the grant; read -> LerMem for LAT_LEITURA cycles, then Ack in the following cycle.
// Backpr. : requests are sampled only while idle; the loser (or a late request) simply waits with Req held until its grant.
//
// Ports:
//   Clock, ResetN                   clock, asynchronous active-low reset
//   Req0/1, Esc0/1, End0/1, Dado0/1 request, write flag, address and write data per port
//   Ack0/1                          one-cycle completion pulse per port
//   DadoLido0/1                     read data captured per port, held until that port's next read
//   EndMemDados, DadoEscritoMem     latched address / write data towards MemoriaDados
//   EscMem, LerMem                  memory write / read enables
//   DadoLidoMem                     data returned by MemoriaDados
//   Ocupado                         high whenever a transaction is in flight

module arbitro_memoria_dados #(
    parameter int LARGURA         = 8,
    parameter int LAT_LEITURA     = 1,
    parameter int PRIORIDADE_FIXA = 0
) (
    input  logic               Clock,
    input  logic               ResetN,
    input  logic               Req0,
    input  logic               Req1,
    input  logic               Esc0,
    input  logic               Esc1,
    input  logic [LARGURA-1:0] End0,
    input  logic [LARGURA-1:0] End1,
    input  logic [LARGURA-1:0] Dado0,
    input  logic [LARGURA-1:0] Dado1,
    output logic               Ack0,
    output logic               Ack1,
    output logic [LARGURA-1:0] DadoLido0,
    output logic [LARGURA-1:0] DadoLido1,
    output logic [LARGURA-1:0] EndMemDados,
    output logic [LARGURA-1:0] DadoEscritoMem,
    output logic               EscMem,
    output logic               LerMem,
    input  logic [LARGURA-1:0] DadoLidoMem,
    output logic               Ocupado
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ESCRITA  = 2'd1,
        LEITURA  = 2'd2,
        RESPOSTA = 2'd3
    } estado_t;

    // Counter value of the last LerMem cycle (LAT_LEITURA is 1..3, so 2 bits suffice).
    localparam logic [1:0] ULTIMA_LEITURA = 2'(LAT_LEITURA - 1);

    estado_t    estado;
    logic       ultimo;          // port granted most recently
    logic       portaAtual;      // port owning the transaction in flight
    logic [1:0] contadorLeitura;

    logic vencedor;
    logic escSel;

    // Winner selection, only meaningful while idle with at least one request.
    always_comb begin
        vencedor = 1'b0;
        if (Req0 && Req1) begin
            // Round-robin hands the tie to the port that did not win last time.
            vencedor = (PRIORIDADE_FIXA != 0) ? 1'b0 : ~ultimo;
        end else begin
            vencedor = Req1;
        end
        escSel = vencedor ? Esc1 : Esc0;
    end

    assign Ocupado = (estado != OCIOSO);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            estado          <= OCIOSO;
            ultimo          <= 1'b1;
            portaAtual      <= 1'b0;
            contadorLeitura <= 2'd0;
            Ack0            <= 1'b0;
            Ack1            <= 1'b0;
            DadoLido0       <= '0;
            DadoLido1       <= '0;
            EndMemDados     <= '0;
            DadoEscritoMem  <= '0;
            EscMem          <= 1'b0;
            LerMem          <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state below re-asserts them.
            Ack0   <= 1'b0;
            Ack1   <= 1'b0;
            EscMem <= 1'b0;
            LerMem <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (Req0 || Req1) begin
                        portaAtual      <= vencedor;
                        ultimo          <= vencedor;
                        EndMemDados     <= vencedor ? End1 : End0;
                        DadoEscritoMem  <= vencedor ? Dado1 : Dado0;
                        contadorLeitura <= 2'd0;
                        if (escSel) begin
                            // A write completes in its only cycle, so Ack rides with EscMem.
                            estado <= ESCRITA;
                            EscMem <= 1'b1;
                            Ack0   <= ~vencedor;
                            Ack1   <= vencedor;
                        end else begin
                            estado <= LEITURA;
                            LerMem <= 1'b1;
                        end
                    end
                end
                ESCRITA: begin
                    estado <= OCIOSO;
                end
                LEITURA: begin
                    if (contadorLeitura == ULTIMA_LEITURA) begin
                        // Memory data is valid on this edge; it is held for the Ack cycle.
                        if (portaAtual) begin
                            DadoLido1 <= DadoLidoMem;
                        end else begin
                            DadoLido0 <= DadoLidoMem;
                        end
                        Ack0   <= ~portaAtual;
                        Ack1   <= portaAtual;
                        estado <= RESPOSTA;
                    end else begin
                        contadorLeitura <= contadorLeitura + 2'd1;
                        LerMem          <= 1'b1;
                    end
                end
                RESPOSTA: begin
                    estado <= OCIOSO;
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: doc/arbitro_memoria_dados.md
Name: arbitro_memoria_dados

Overview:
- Shares the single MemoriaDados port between two requesters: port 0 is the nRisc core's load/store path; port 1 is a loader/debug master that fills or inspects data memory.
- Sequences every access as a registered transaction: one write cycle, or LAT_LEITURA read cycles followed by a response cycle.
- Sits between the masters and MemoriaDados and drives EndMemDados, DadoEscritoMem, EscMem and LerMem.

Parameters:
- LARGURA, 8, width of the address and data buses.
- LAT_LEITURA, 1, cycles LerMem is held before DadoLidoMem is valid; legal range 1..3.
- PRIORIDADE_FIXA, 0. 0 = round-robin between the ports; 1 = port 0 always wins a tie.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- Req0 / Req1  in  1  access request from port 0 / port 1.
- Esc0 / Esc1  in  1  1 = write, 0 = read.
- End0 / End1  in  LARGURA  access address.
- Dado0 / Dado1  in  LARGURA  write data.
- Ack0 / Ack1  out  1  one-cycle completion pulse.
- DadoLido0 / DadoLido1  out  LARGURA  read data, registered per port.
- EndMemDados  out  LARGURA  address to MemoriaDados.
- DadoEscritoMem  out  LARGURA  write data to MemoriaDados.
- EscMem  out  1  memory write enable.
- LerMem  out  1  memory read enable.
- DadoLidoMem  in  LARGURA  data returned by MemoriaDados.
- Ocupado  out  1  high whenever the FSM is not in OCIOSO.

Behaviour:
- Reset (ResetN=0, asynchronous) forces:
  - state = OCIOSO;
  - all outputs = 0;
  - Ultimo = 1, so port 0 wins the first tie;
  - read counter = 0.
- Reset mid-transaction aborts it immediately: EscMem and LerMem drop asynchronously, and no Ack is issued.
- States and transitions:
  - OCIOSO: sample Req0/Req1. If neither is set, stay. Otherwise select a winner k, latch Endk/Dadok/Esck into the memory output registers, set Ultimo=k, and go to ESCRITA (Esck=1) or LEITURA (Esck=0).
  - ESCRITA: EscMem=1 and Ackk=1 for exactly this one cycle, then go to OCIOSO.
  - LEITURA: LerMem=1 for LAT_LEITURA consecutive cycles, counted by the read counter. On the edge ending the last cycle, capture DadoLidoMem into DadoLidok, then go to RESPOSTA.
  - RESPOSTA: Ackk=1 for one cycle, with DadoLidok already stable; then go to OCIOSO.
- Arbitration, when both ports request in OCIOSO:
  - PRIORIDADE_FIXA=0: grant the port that is not Ultimo.
  - PRIORIDADE_FIXA=1: grant port 0.
  - A single requester is always granted.
- Latency, with Req seen high in OCIOSO during cycle N:
  - write: EscMem and Ack in cycle N+1;
  - read: LerMem in cycles N+1..N+LAT_LEITURA, Ack in cycle N+LAT_LEITURA+1.
  - Back-to-back throughput: one write per 2 cycles; one read per LAT_LEITURA+2 cycles.
- Handshake:
  - The requester holds Req/Esc/End/Dado stable until it sees Ack.
  - The requester must deassert Req on the edge where Ack is seen, or keep it high to request again.
  - Req is sampled only in OCIOSO.
  - Dropping Req before Ack does not cancel the transaction: the latched values complete and Ack is still pulsed.
- Held values:
  - DadoLidok holds until the next read completes for that port; the non-winning port's DadoLido never changes.
  - EndMemDados and DadoEscritoMem hold their last latched values in OCIOSO.
- Invariants:
  - EscMem and LerMem are never high in the same cycle.
  - Ack0 and Ack1 are never high in the same cycle.
  - At most one Ack per grant.
  - The Acks, EscMem and LerMem are registered (no combinational path from Req).
- Ocupado = (state != OCIOSO).

Test Plan:
- Reset, then Req0=1, Esc0=1, End0=8'h10, Dado0=8'h5A in cycle N -> EscMem=1, EndMemDados=8'h10, DadoEscritoMem=8'h5A and Ack0=1 all in cycle N+1, single cycle; Ack1 stays 0.
- After the write above, LAT_LEITURA=1, Req1=1, Esc1=0, End1=8'h10 -> LerMem=1 in N+1, Ack1=1 in N+2, DadoLido1=8'h5A; DadoLido0 unchanged.
- Req0 and Req1 both held high continuously (reads, PRIORIDADE_FIXA=0) -> grants alternate 0,1,0,1 starting with port 0; no Ack overlap; EscMem never high.
- Same as the previous scenario with PRIORIDADE_FIXA=1 -> port 0 granted every time and port 1 starves; LAT_LEITURA=3 gives LerMem high for 3 cycles and Ack on the 4th.
- ResetN pulsed low during LEITURA -> LerMem and Ocupado go 0 immediately; no Ack is issued; after release, Req0 is served with first-tie priority to port 0.
- Req0 dropped the cycle after a write grant -> EscMem and Ack0 still issued once; FSM returns to OCIOSO with Ocupado=0.
